// File: rtl/spi_regbank_burst_if.sv
// Serial bus plus core write-strobe bundle for spi_regbank_burst.
// master drives CSN/MOSI; slave (the register bank) drives everything else.
interface spi_regbank_burst_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              CSN;
  logic              MOSI;
  logic              MISO;
  logic              MISO_enable;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;

  modport master (
    output CSN, MOSI,
    input  MISO, MISO_enable, reg_wr, reg_waddr, reg_wdata
  );

  modport slave (
    input  CSN, MOSI,
    output MISO, MISO_enable, reg_wr, reg_waddr, reg_wdata
  );
endinterface

// File: rtl/spi_regbank_burst.sv
// SPI-style register bank: MSB-first R/W + address + turnaround + data + tail frames into a
// 2^ADDR_W x DATA_W register file, with optional auto-increment bursts while CSN stays low.
module spi_regbank_burst #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TURN_BITS = 5,
  parameter int unsigned TAIL_BITS = 5,
  parameter int unsigned BURST_EN  = 1
) (
  input logic                SCLK,
  input logic                rst,
  spi_regbank_burst_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = $clog2(ADDR_W + TURN_BITS + DATA_W + TAIL_BITS + 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_W - 1);
  localparam logic [CntW-1:0] TurnLast = CntW'(TURN_BITS - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] TailLast = CntW'(TAIL_BITS - 1);

  typedef enum logic [2:0] {StCmd, StAddr, StTurn, StData, StTail, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              miso_q, miso_d;
  logic              men_q, men_d;
  logic              reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [DATA_W-1:0] mem_q [Depth];

  logic              wr_en;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] wdata;

  // The only load from TAIL is the next burst word, so it always targets addr+1.
  assign load_addr = (state_q == StTail) ? addr_q + ADDR_W'(1) : addr_q;
  assign rdata     = mem_q[load_addr];
  assign wdata     = {sr_q[DATA_W-2:0], bus.MOSI};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    rw_d    = rw_q;
    addr_d  = addr_q;
    sr_d    = sr_q;
    miso_d  = miso_q;
    men_d   = men_q;
    wr_en   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StCmd: begin
        rw_d    = bus.MOSI;
        state_d = StAddr;
        cnt_d   = '0;
      end
      StAddr: begin
        addr_d = {addr_q[ADDR_W-2:0], bus.MOSI};
        if (cnt_q == AddrLast) begin
          state_d = StTurn;
          cnt_d   = '0;
        end
      end
      StTurn: begin
        if (cnt_q == TurnLast) begin
          state_d = StData;
          cnt_d   = '0;
          load    = ~rw_q;
        end
      end
      StData: begin
        if (rw_q) begin
          sr_d = wdata;
        end else begin
          miso_d = sr_q[DATA_W-1];
          sr_d   = sr_q << 1;
        end
        if (cnt_q == DataLast) begin
          state_d = StTail;
          cnt_d   = '0;
          wr_en   = rw_q;
          men_d   = 1'b0;
          miso_d  = 1'b0;
        end
      end
      StTail: begin
        if (cnt_q == TailLast) begin
          cnt_d = '0;
          if (BURST_EN != 0) begin
            state_d = StData;
            addr_d  = load_addr;
            load    = ~rw_q;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  cnt_d = cnt_q;
      default: state_d = StCmd;
    endcase
    // Preload the word so its MSB is already on MISO when the first data edge samples it.
    if (load) begin
      sr_d   = rdata << 1;
      miso_d = rdata[DATA_W-1];
      men_d  = 1'b1;
    end
  end

  assign reg_wr_d    = wr_en;
  assign reg_waddr_d = wr_en ? addr_q : reg_waddr_q;
  assign reg_wdata_d = wr_en ? wdata : reg_wdata_q;

  // Frame state is held clear whenever the chip is deselected.
  always_ff @(posedge SCLK or posedge rst or posedge bus.CSN) begin
    if (rst || bus.CSN) begin
      state_q <= StCmd;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      sr_q    <= '0;
      miso_q  <= 1'b0;
      men_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      miso_q  <= miso_d;
      men_q   <= men_d;
    end
  end

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      reg_wr_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      if (wr_en) mem_q[addr_q] <= wdata;
      reg_wr_q    <= reg_wr_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign bus.MISO_enable = men_q & ~bus.CSN;
  assign bus.MISO        = miso_q & bus.MISO_enable;
  assign bus.reg_wr      = reg_wr_q;
  assign bus.reg_waddr   = reg_waddr_q;
  assign bus.reg_wdata   = reg_wdata_q;

endmodule

// File: tb/tb_spi_regbank_burst.sv
// Scoreboard bench: a burst-enabled and a burst-disabled instance share one serial master;
// a word-level register-file model queues expected writes and read words per instance.
module tb_spi_regbank_burst;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  logic csn  = 1'b1;
  logic mosi = 1'b0;

  int checks = 0;
  int errors = 0;
  bit abort_ok = 1'b0;

  logic [23:0] wr_q [2][$];
  logic [15:0] rd_q [2][$];
  logic [15:0] mem_m [2][256];
  logic [15:0] wbuf [4];

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_regbank_burst_if #(.ADDR_W(8), .DATA_W(16)) bus ();
    logic [15:0] sh = '0;
    int nb = 0;

    assign bus.CSN  = csn;
    assign bus.MOSI = mosi;

    spi_regbank_burst #(
      .ADDR_W   (8),
      .DATA_W   (16),
      .TURN_BITS(5),
      .TAIL_BITS(5),
      .BURST_EN (g == 0 ? 1 : 0)
    ) u_dut (
      .SCLK(sclk),
      .rst (rst),
      .bus (bus)
    );

    always @(negedge sclk) begin
      if (bus.reg_wr) begin
        if (wr_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL reg_wr dut%0d: got write %h=%h required none", g, bus.reg_waddr,
                   bus.reg_wdata);
        end else begin
          chk($sformatf("reg_wr dut%0d", g), {8'h0, bus.reg_waddr, bus.reg_wdata},
              {8'h0, wr_q[g].pop_front()});
        end
      end
      if (bus.MISO_enable) begin
        sh = {sh[14:0], bus.MISO};
        nb++;
        if (nb == 16) begin
          nb = 0;
          if (rd_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read dut%0d: got word %h required none", g, sh);
          end else begin
            chk($sformatf("read dut%0d", g), 32'(sh), 32'(rd_q[g].pop_front()));
          end
        end
      end else begin
        chk($sformatf("idle miso dut%0d", g), 32'(bus.MISO), 32'(0));
        if (!abort_ok) chk($sformatf("enable length dut%0d", g), 32'(nb), 32'(0));
        nb = 0;
      end
    end
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, " miso0"}, 32'(g_dut[0].bus.MISO), 32'(0));
    chk({tag, " men0"}, 32'(g_dut[0].bus.MISO_enable), 32'(0));
    chk({tag, " wr0"}, 32'(g_dut[0].bus.reg_wr), 32'(0));
    chk({tag, " waddr0"}, 32'(g_dut[0].bus.reg_waddr), 32'(0));
    chk({tag, " wdata0"}, 32'(g_dut[0].bus.reg_wdata), 32'(0));
    chk({tag, " miso1"}, 32'(g_dut[1].bus.MISO), 32'(0));
    chk({tag, " men1"}, 32'(g_dut[1].bus.MISO_enable), 32'(0));
    chk({tag, " wr1"}, 32'(g_dut[1].bus.reg_wr), 32'(0));
    chk({tag, " waddr1"}, 32'(g_dut[1].bus.reg_waddr), 32'(0));
    chk({tag, " wdata1"}, 32'(g_dut[1].bus.reg_wdata), 32'(0));
  endtask

  // One frame of nw words; cut >= 0 ends it after that many data bits (by CSN or by rst).
  task automatic frame(input bit rw, input logic [7:0] addr, input int nw, input int cut,
                       input bit by_rst);
    logic [7:0] a;
    int n;
    int sent;
    sent = 0;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? nw : 1;
      for (int w = 0; w < n; w++) begin
        if (cut >= 0 && cut < (w + 1) * 16) break;
        a = addr + 8'(w);
        if (rw) begin
          mem_m[d][a] = wbuf[w];
          wr_q[d].push_back({a, wbuf[w]});
        end else begin
          rd_q[d].push_back(mem_m[d][a]);
        end
      end
    end
    csn  = 1'b0;
    mosi = rw;
    step();
    for (int i = 7; i >= 0; i--) begin
      mosi = addr[i];
      step();
    end
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom);
      step();
    end
    for (int w = 0; w < nw; w++) begin
      for (int b = 15; b >= 0; b--) begin
        if (sent == cut) begin
          abort_ok = 1'b1;
          if (by_rst) begin
            rst = 1'b1;
            #1;
            rst_chk("mid-frame rst");
            step();
            rst  = 1'b0;
            mosi = 1'b0;
            for (int d = 0; d < 2; d++)
              for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
          end else begin
            csn  = 1'b1;
            mosi = 1'b0;
            step();
            step();
          end
          abort_ok = 1'b0;
          return;
        end
        mosi = rw ? wbuf[w][b] : 1'($urandom);
        step();
        sent++;
      end
      for (int i = 0; i < 5; i++) begin
        mosi = 1'($urandom);
        step();
      end
    end
    csn  = 1'b1;
    mosi = 1'b0;
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit   rw;
    int   nw;
    int   cut;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
    repeat (3) step();
    rst_chk("reset");
    rst = 1'b0;
    step();

    // Single write then read back.
    wbuf[0] = 16'hA5C3;
    frame(1'b1, 8'h12, 1, -1, 1'b0);
    frame(1'b0, 8'h12, 1, -1, 1'b0);

    // Wrapping burst write; the non-burst instance keeps only the first word.
    wbuf[0] = 16'h1111;
    wbuf[1] = 16'h2222;
    wbuf[2] = 16'h3333;
    frame(1'b1, 8'hFE, 3, -1, 1'b0);
    frame(1'b0, 8'hFE, 1, -1, 1'b0);
    frame(1'b0, 8'hFF, 1, -1, 1'b0);
    frame(1'b0, 8'h00, 1, -1, 1'b0);
    frame(1'b0, 8'hFF, 2, -1, 1'b0);

    // Write cancelled after 8 data bits.
    wbuf[0] = 16'hFFFF;
    frame(1'b1, 8'h40, 1, 8, 1'b0);
    frame(1'b0, 8'h40, 1, -1, 1'b0);

    for (int k = 0; k < 24; k++) begin
      rw  = 1'($urandom);
      nw  = int'($urandom_range(1, 3));
      for (int w = 0; w < 4; w++) wbuf[w] = 16'($urandom);
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32'(nw * 16 - 1))) : -1;
      frame(rw, 8'($urandom), nw, cut, 1'b0);
    end

    // Reset in the middle of reading an all-ones word, then a CMD with CSN still low.
    wbuf[0] = 16'hFFFF;
    frame(1'b1, 8'h12, 1, -1, 1'b0);
    frame(1'b0, 8'h12, 1, 5, 1'b1);
    frame(1'b0, 8'h00, 256, -1, 1'b0);

    wbuf[0] = 16'h5A0F;
    frame(1'b1, 8'h7E, 1, -1, 1'b0);
    frame(1'b0, 8'h7E, 1, -1, 1'b0);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pending writes dut%0d", d), 32'(wr_q[d].size()), 32'(0));
      chk($sformatf("pending reads dut%0d", d), 32'(rd_q[d].size()), 32'(0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
